// File: rtl/tile_plane_stepper.sv
// -----------------------------------------------------------------------------
// tile_plane_stepper
//
// Walks one TILE_W x TILE_H tile in row-major order and emits the plane
//   Z = x*ddx + y*ddy + c
// at every pixel. Z is produced incrementally: one add per pixel along a row,
// one add per row from a row-start register. The plane is evaluated explicitly
// only once per walk, at the tile origin.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   load       start a walk with ddx/ddy/c/x0/y0 (ignored while busy)
//   ddx,ddy,c  signed 64-bit plane coefficients, FRAC_BITS fractional bits
//   x0,y0      signed 32-bit integer pixel origin of the tile
//   busy       walk in progress (SETUP, RUN or DONE)
//   out_valid  out_z/out_x/out_y hold a pixel
//   out_ready  consumer accepts the current pixel
//   out_z      interpolated value at (out_x, out_y)
//   out_x,out_y pixel coordinates
//   out_last   current pixel is the final one of the tile
//   done       one-cycle pulse after the last pixel handshake
// -----------------------------------------------------------------------------
module tile_plane_stepper #(
  parameter int FRAC_BITS = 12,
  parameter int TILE_W    = 32,
  parameter int TILE_H    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic signed [63:0] ddx,
  input  logic signed [63:0] ddy,
  input  logic signed [63:0] c,
  input  logic signed [31:0] x0,
  input  logic signed [31:0] y0,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [63:0] out_z,
  output logic signed [31:0] out_x,
  output logic signed [31:0] out_y,
  output logic               out_last,
  output logic               done
);

  // FRAC_BITS only documents the fixed-point format; the stepping arithmetic
  // is format-agnostic because every operand shares the same scaling.
  localparam int COL_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int ROW_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(TILE_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(TILE_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Captured walk parameters
  logic signed [63:0] ddx_q, ddy_q, c_q;
  logic signed [31:0] x0_q, y0_q;

  // Stepping datapath
  logic signed [63:0] acc_q;       // Z of the current pixel
  logic signed [63:0] rowstart_q;  // Z of column 0 of the current row
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;

  logic               at_row_end;
  logic               at_last;
  logic               handshake;
  logic signed [63:0] start_z;
  logic signed [63:0] x0_ext, y0_ext;

  assign at_row_end = (col_q == COL_MAX);
  assign at_last    = at_row_end && (row_q == ROW_MAX);
  assign handshake  = (state_q == RUN) && out_ready;

  // Plane value at the origin. Products are kept in a 64-bit context so they
  // truncate to the low 64 bits and the sum wraps; this matches the wrap of
  // the per-pixel accumulation, so the incremental result equals the direct
  // evaluation modulo 2^64.
  assign x0_ext  = 64'(x0_q);
  assign y0_ext  = 64'(y0_q);
  assign start_z = c_q + x0_ext * ddx_q + y0_ext * ddy_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (load) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        out_last  = at_last;
        if (out_ready && at_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture registers: written only from IDLE, so a load while busy has no
  // effect and nothing is remembered for later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ddx_q <= '0;
      ddy_q <= '0;
      c_q   <= '0;
      x0_q  <= '0;
      y0_q  <= '0;
    end else if (state_q == IDLE && load) begin
      ddx_q <= ddx;
      ddy_q <= ddy;
      c_q   <= c;
      x0_q  <= x0;
      y0_q  <= y0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stepping datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      rowstart_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else if (state_q == SETUP) begin
      acc_q      <= start_z;
      rowstart_q <= start_z;
      col_q      <= '0;
      row_q      <= '0;
    end else if (handshake && !at_last) begin
      if (at_row_end) begin
        // Step down from the row start rather than back from the row end,
        // so no subtraction is needed.
        rowstart_q <= rowstart_q + ddy_q;
        acc_q      <= rowstart_q + ddy_q;
        col_q      <= '0;
        row_q      <= row_q + 1'b1;
      end else begin
        acc_q <= acc_q + ddx_q;
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Pixel outputs are direct views of the datapath; they cannot move while
  // stalled because the datapath only steps on a handshake.
  assign out_z = acc_q;
  assign out_x = x0_q + 32'(col_q);
  assign out_y = y0_q + 32'(row_q);

endmodule
